// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the four request sources and the round-robin
// arbiter that drives the 4-to-1 mux select.
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   // Sources / datapath side: drives requests and completion, sees the grant.
   modport master (
      output req,
      output done,
      input  grant,
      input  sel,
      input  busy,
      input  timeout
   );

   // Arbiter side.
   modport slave (
      input  req,
      input  done,
      output grant,
      output sel,
      output busy,
      output timeout
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four sources feeding a 4-to-1 mux. Grants one
// source at a time, holds the grant until done, request withdrawal or the
// hold limit, and exports a registered one-hot grant, mux select, busy flag
// and a one-cycle timeout pulse. All outputs come straight from registers.
module mux4_rr_arbiter #(
   parameter int HOLD_MAX = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   mux4_rr_arbiter_if.slave bus
);

   // Last legal counter value; reaching it on a sampling edge forces release.
   localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_reg, state_next;
   logic [1:0] ptr_reg, ptr_next;
   logic [7:0] cnt_reg, cnt_next;
   logic [3:0] grant_reg, grant_next;
   logic [1:0] sel_reg, sel_next;
   logic       busy_reg, busy_next;
   logic       timeout_reg, timeout_next;

   // Requests rotated so that position 0 is the source the pointer favours.
   logic [3:0] rot_req;
   logic       pick_valid;
   logic [1:0] pick_idx;

   // Release conditions for the current owner (owner index lives in sel_reg).
   logic owner_req;
   logic hold_expired;
   logic release_now;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         assign rot_req[gi] = bus.req[ptr_reg + 2'(gi)];
      end
   endgenerate

   // First requester at or after the pointer, wrapping modulo 4.
   always_comb begin
      pick_valid = |rot_req;
      pick_idx   = ptr_reg;
      for (int k = 3; k >= 0; k--) begin
         if (rot_req[k]) begin
            pick_idx = ptr_reg + 2'(k);
         end
      end
   end

   assign owner_req    = bus.req[sel_reg];
   assign hold_expired = (cnt_reg == CNT_LAST);
   assign release_now  = bus.done | ~owner_req | hold_expired;

   // State register together with the registered outputs; async active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ptr_reg     <= 2'd0;
         cnt_reg     <= 8'd0;
         grant_reg   <= 4'b0000;
         sel_reg     <= 2'd0;
         busy_reg    <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         cnt_reg     <= cnt_next;
         grant_reg   <= grant_next;
         sel_reg     <= sel_next;
         busy_reg    <= busy_next;
         timeout_reg <= timeout_next;
      end
   end

   // Next-state logic: state, fairness pointer and hold counter.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               state_next = GRANT;
               cnt_next   = 8'd0;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_next = IDLE;
               ptr_next   = sel_reg + 2'd1;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered grant/sel/busy/timeout.
   always_comb begin
      grant_next   = grant_reg;
      sel_next     = sel_reg;
      busy_next    = busy_reg;
      timeout_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               grant_next = 4'b0001 << pick_idx;
               sel_next   = pick_idx;
               busy_next  = 1'b1;
            end
         end
         GRANT: begin
            if (release_now) begin
               grant_next   = 4'b0000;
               busy_next    = 1'b0;
               // Pulse only when the hold limit alone forced the release.
               timeout_next = hold_expired & ~bus.done & owner_req;
            end
         end
         default: begin
            grant_next = 4'b0000;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign bus.grant   = grant_reg;
   assign bus.sel     = sel_reg;
   assign bus.busy    = busy_reg;
   assign bus.timeout = timeout_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter (HOLD_MAX = 4), plus
// hand-written sequences for asynchronous reset and hold-limit timing.
module tb_mux4_rr_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mux4_rr_arbiter_if bus ();

   mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic       done;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       timeout;
   } vec_t;

   localparam int NVEC = 36;
   vec_t vecs [NVEC];

   task automatic check(input string name, input int step,
                        input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h want=%0h", name, step, got, want);
      end
   endtask

   task automatic check_all(input int step, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic t);
      check("grant",   step, 8'(bus.grant),   8'(g));
      check("sel",     step, 8'(bus.sel),     8'(s));
      check("busy",    step, 8'(bus.busy),    8'(b));
      check("timeout", step, 8'(bus.timeout), 8'(t));
   endtask

   initial begin
      int held;
      logic seen_to;

      checks   = 0;
      failures = 0;

      //            rst   req      done  grant    sel   busy  to
      // Reset, then first grant from reset with all requesting.
      vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      // Pointer order from reset: 0110 -> source 1, done, then source 2.
      vecs[2]  = '{1'b0, 4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 4'b0110, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      // Fairness and wrap: all requesting, done on 2nd grant cycle.
      vecs[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[17] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[18] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[20] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      // Timeout: lone requester held 4 cycles, pulse, then re-grant.
      vecs[22] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[23] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[24] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[25] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[26] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1};
      vecs[27] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      // done coinciding with the hold limit: no timeout pulse.
      vecs[28] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[29] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[30] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[31] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
      // Owner drops its request mid-grant: release, no timeout, idle holds sel.
      vecs[32] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[33] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[34] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
      vecs[35] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};

      // Reset asserted with all sources requesting; no clock edge needed.
      bus.req  = 4'b1111;
      bus.done = 1'b0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_all(-1, 4'b0000, 2'd0, 1'b0, 1'b0);
      $display("reset  req=%b grant=%b sel=%0d busy=%b timeout=%b",
               bus.req, bus.grant, bus.sel, bus.busy, bus.timeout);

      for (int i = 0; i < NVEC; i++) begin
         rst_n    = vecs[i].rst_n;
         bus.req  = vecs[i].req;
         bus.done = vecs[i].done;
         @(posedge clk);
         #1;
         check_all(i, vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].timeout);
         $display("vec %0d rst_n=%b req=%b done=%b grant=%b sel=%0d busy=%b timeout=%b",
                  i, rst_n, bus.req, bus.done, bus.grant, bus.sel, bus.busy, bus.timeout);
      end

      // Asynchronous reset while source 3 owns the grant (pointer is 3 here).
      bus.req = 4'b1000;
      @(posedge clk);
      #1;
      check_all(100, 4'b1000, 2'd3, 1'b1, 1'b0);
      $display("async  pre-reset grant=%b sel=%0d", bus.grant, bus.sel);
      #2 rst_n = 1'b0;
      #1;
      check_all(101, 4'b0000, 2'd0, 1'b0, 1'b0);
      $display("async  mid-cycle reset grant=%b busy=%b", bus.grant, bus.busy);
      rst_n   = 1'b1;
      bus.req = 4'b1001;
      @(posedge clk);
      #1;
      check_all(102, 4'b0001, 2'd0, 1'b1, 1'b0);
      $display("async  post-reset req=%b grant=%b", bus.req, bus.grant);

      // Hold-limit length: source 0 alone, bounded wait for the release.
      bus.req = 4'b0001;
      held    = 1;
      seen_to = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (bus.busy) begin
            held++;
         end else begin
            seen_to = bus.timeout;
            break;
         end
      end
      check("hold_cycles", 103, 8'(held), 8'd4);
      check("hold_timeout", 103, 8'(seen_to), 8'd1);
      $display("hold   cycles=%0d timeout=%b", held, seen_to);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
